// File: rtl/score_pkg.sv
// Shared types and constants for the score event scheduler.
// The optional BCD readout is enabled by defining SCORE_BCD_EN.
package score_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ADD  = 1'b1
   } sched_state_t;

   localparam int SCORE_MAX_DEFAULT = 999;

   // Hundreds, tens and ones digits, ones in the lowest nibble.
   typedef logic [2:0][3:0] bcd3_t;

endpackage

// File: rtl/score_bcd_conv.sv
// Iterative double-dabble converter from binary score to three BCD digits.
// Built only when SCORE_BCD_EN is defined; a new start restarts the conversion.
module score_bcd_conv
   import score_pkg::*;
#(
   parameter int SCORE_W = 10
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output bcd3_t              bcd,
   output logic               valid
);

   localparam int CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0] bin_sh;
   bcd3_t              acc;
   bcd3_t              acc_adj;
   logic [11:0]        acc_next;
   logic [CNT_W-1:0]   cnt;
   logic               run;

   // Add-3 correction on every digit of 5 or more, then shift in the next binary bit.
   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < 3; d++) begin
         if (acc[d] >= 4'd5) acc_adj[d] = acc[d] + 4'd3;
      end
      acc_next = {acc_adj[2:0][10:0], bin_sh[SCORE_W-1]};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bin_sh <= '0;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b0;
         bcd    <= '0;
         valid  <= 1'b1;
      end else if (start) begin
         bin_sh <= bin;
         acc    <= '0;
         cnt    <= CNT_W'(SCORE_W);
         run    <= 1'b1;
         valid  <= 1'b0;
      end else if (run) begin
         acc    <= acc_next;
         bin_sh <= bin_sh << 1;
         cnt    <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            run   <= 1'b0;
            valid <= 1'b1;
            bcd   <= acc_next;
         end
      end
   end

endmodule

// File: rtl/score_event_sched.sv
// Round-robin scheduler granting coin/goomba score events into one saturating
// accumulator, plus the vsync-driven animation frame counter (BCD readout: SCORE_BCD_EN).
module score_event_sched
   import score_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int SCORE_W   = 10,
   parameter int SCORE_MAX = SCORE_MAX_DEFAULT,
   parameter int INC_W     = 4,
   parameter int FRAME_W   = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     vs_in,
   input  logic                     clear,
   input  logic [NUM_SRC-1:0]       src_hit,
   input  logic [NUM_SRC*INC_W-1:0] src_inc,
   input  logic                     anim_en,
   input  logic                     anim_step,
   output logic [SCORE_W-1:0]       score,
   output logic                     score_upd,
   output logic [NUM_SRC-1:0]       awarded,
   output logic [NUM_SRC-1:0]       grant,
   output logic [FRAME_W-1:0]       anim_frame,
   output logic                     busy
`ifdef SCORE_BCD_EN
   ,
   output logic [11:0]              score_bcd,
   output logic                     bcd_valid
`endif
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   sched_state_t        state, state_nxt;
   logic [NUM_SRC-1:0]  pending, pending_nxt;
   logic [NUM_SRC-1:0]  awarded_nxt, grant_nxt;
   logic [PTR_W-1:0]    ptr, g_idx, ptr_inc;
   logic [SCORE_W-1:0]  score_q;
   logic [SCORE_W:0]    sum;
   logic [INC_W-1:0]    inc_arr [NUM_SRC];
   logic [INC_W-1:0]    inc_g;
   logic                do_award;
   logic                vs_q;
   logic                frame_tick;

   // First requesting source at or after start, wrapping past the top index.
   function automatic logic [NUM_SRC-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                  input logic [PTR_W-1:0]   start);
      logic [NUM_SRC-1:0] pick;
      logic [PTR_W-1:0]   sel;
      logic               found;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         sel = PTR_W'((int'(start) + k) % NUM_SRC);
         if (!found && req[sel]) begin
            pick[sel] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [PTR_W-1:0] oh_idx(input logic [NUM_SRC-1:0] oh);
      logic [PTR_W-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (oh[k]) r = PTR_W'(k);
      end
      return r;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W:0] s);
      if (s > (SCORE_W+1)'(SCORE_MAX)) return SCORE_W'(SCORE_MAX);
      return s[SCORE_W-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) inc_arr[i] = src_inc[i*INC_W +: INC_W];
   end

   assign frame_tick = vs_in & ~vs_q;
   assign g_idx      = oh_idx(grant);
   assign inc_g      = inc_arr[g_idx];
   assign sum        = {1'b0, score_q} + {{(SCORE_W+1-INC_W){1'b0}}, inc_g};
   assign ptr_inc    = PTR_W'((int'(g_idx) + 1) % NUM_SRC);
   assign score      = score_q;
   assign busy       = (state != IDLE) | (|pending);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // clear overrides everything, including an award in flight.
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant;
      do_award    = 1'b0;
      case (state)
         IDLE: begin
            if (|pending) begin
               grant_nxt = rr_pick(pending, ptr);
               state_nxt = ADD;
            end
         end
         ADD: begin
            do_award  = 1'b1;
            grant_nxt = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Already-awarded sources are masked, so a held hit on the granted source is not re-queued.
      pending_nxt = pending | (src_hit & ~awarded);
      awarded_nxt = awarded;
      if (do_award) begin
         pending_nxt = pending_nxt & ~grant;
         awarded_nxt = awarded | grant;
      end

      if (clear) begin
         state_nxt   = IDLE;
         grant_nxt   = '0;
         do_award    = 1'b0;
         pending_nxt = '0;
         awarded_nxt = '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_q       <= 1'b0;
         pending    <= '0;
         awarded    <= '0;
         grant      <= '0;
         ptr        <= '0;
         score_q    <= '0;
         score_upd  <= 1'b0;
         anim_frame <= '0;
      end else begin
         vs_q      <= vs_in;
         pending   <= pending_nxt;
         awarded   <= awarded_nxt;
         grant     <= grant_nxt;
         score_upd <= do_award;
         if (clear) begin
            score_q    <= '0;
            ptr        <= '0;
            anim_frame <= '0;
         end else begin
            if (do_award) begin
               score_q <= sat_score(sum);
               ptr     <= ptr_inc;
            end
            if (frame_tick && anim_en && anim_step) anim_frame <= anim_frame + FRAME_W'(1);
         end
      end
   end

`ifdef SCORE_BCD_EN
   bcd3_t bcd_w;

   score_bcd_conv #(
      .SCORE_W (SCORE_W)
   ) u_bcd_conv (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .start   (score_upd),
      .bin     (score_q),
      .bcd     (bcd_w),
      .valid   (bcd_valid)
   );

   assign score_bcd = bcd_w;
`endif

endmodule
